// File: rtl/piso_tx_param_pkg.sv
// ---------------------------------------------------------------------------
// piso_tx_param_pkg
// Shared definitions for the parameterised serial transmitter:
//   - legal DATA_W range and width of the data_length field
//   - parity_type encodings
//   - transmitter FSM state encoding
//   - helpers for length clamping and parity generation
// ---------------------------------------------------------------------------
package piso_tx_param_pkg;

    // Legal range for the DATA_W parameter (and for data_length at run time).
    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    // Width of the data_length field carried with every buffered word.
    localparam int LEN_W = 4;

    // parity_type encodings; 11 behaves like 00.
    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_ODD      = 2'b01,
        PAR_EVEN     = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_t;

    // Transmitter FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // A requested length outside DATA_W_MIN..data_w falls back to data_w.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len,
                                                 input int                data_w);
        if (int'(len) < DATA_W_MIN || int'(len) > data_w) begin
            return LEN_W'(data_w);
        end
        return len;
    endfunction

    // True for the two modes that insert a parity bit.
    function automatic logic parity_enabled(input parity_t mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

    // Parity over the low 'len' bits only; 0 when the frame carries no parity.
    function automatic logic calc_parity(input logic [DATA_W_MAX-1:0] data,
                                         input logic [LEN_W-1:0]      len,
                                         input parity_t               mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < DATA_W_MAX; i++) begin
            if (i < int'(len)) begin
                x = x ^ data[i];
            end
        end
        case (mode)
            PAR_ODD:  return ~x;
            PAR_EVEN: return x;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/piso_tx_param_tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo
// Small first-word-fall-through holding buffer for the transmitter. The head
// word is visible on o_data whenever o_empty is low, so the FSM can pop and
// load it on the same edge.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (clears pointers and count)
//   i_push   write request; ignored while full
//   i_data   word to write
//   i_pop    read request; ignored while empty
//   o_data   head word
//   o_full   count == DEPTH
//   o_empty  count == 0
//   o_count  number of buffered words
// ---------------------------------------------------------------------------
module tx_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_mem [DEPTH];
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A push while full is dropped; a push and pop on the same edge while
    // full is also dropped since ready was low when the push was presented.
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Storage: one register per entry, written when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] r_word;
            always_ff @(posedge i_clk) begin
                if (w_do_push && (r_wr_ptr == AW'(gi))) begin
                    r_word <= i_data;
                end
            end
            assign w_mem[gi] = r_word;
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = w_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/piso_tx_param.sv
// ---------------------------------------------------------------------------
// piso_tx_param
// Parallel-in / serial-out frame transmitter with a small holding buffer.
// Each accepted word carries its own frame format (length, parity, stop bits)
// captured at the moment of acceptance. Frames are sent as
//   start(0) | data bits LSB first | optional parity | 1 or 2 stop(1)
// and back-to-back frames follow each other with no idle bit.
//
// Ports:
//   BaudOut       bit clock, one serial bit per rising edge
//   rst           asynchronous active-low reset
//   send          write strobe, accepted when ready=1
//   data_in       data word, bit 0 sent first
//   data_length   data bits per frame (5..DATA_W, anything else -> DATA_W)
//   parity_type   00 none, 01 odd, 10 even, 11 none
//   stop_bits     0 one stop bit, 1 two stop bits
//   ready         buffer not full
//   data_out      serial line, idle high
//   p_parity_out  parity of the frame in flight (0 when no parity)
//   tx_active     frame in progress
//   tx_done       one-cycle pulse after each frame's last stop bit
//   fifo_count    words buffered
// ---------------------------------------------------------------------------
module piso_tx_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          BaudOut,
    input  logic                          rst,
    input  logic                          send,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [3:0]                    data_length,
    input  logic [1:0]                    parity_type,
    input  logic                          stop_bits,
    output logic                          ready,
    output logic                          data_out,
    output logic                          p_parity_out,
    output logic                          tx_active,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    import piso_tx_param_pkg::*;

    // Buffered word layout: {stop_bits, parity_type, effective length, data}
    localparam int LEN_LSB  = DATA_W;
    localparam int PAR_LSB  = DATA_W + LEN_W;
    localparam int STOP_BIT = DATA_W + LEN_W + 2;
    localparam int WORD_W   = DATA_W + LEN_W + 3;

    // ---------------------------------------------------------------------
    // Holding buffer
    // ---------------------------------------------------------------------
    logic [WORD_W-1:0] w_push_word;
    logic [WORD_W-1:0] w_head_word;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;

    // Length is clamped once at acceptance so the FSM only sees legal values.
    assign w_push_word = {stop_bits, parity_type,
                          eff_len(data_length, DATA_W), data_in};

    tx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (BaudOut),
        .i_rst_n (rst),
        .i_push  (send),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (w_head_word),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign ready = !w_fifo_full;

    // ---------------------------------------------------------------------
    // Head word decode
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0]     w_head_data;
    logic [DATA_W_MAX-1:0] w_head_data_ext;
    logic [LEN_W-1:0]      w_head_len;
    parity_t               w_head_mode;
    logic                  w_head_stop2;
    logic                  w_head_parity;

    assign w_head_data  = w_head_word[DATA_W-1:0];
    assign w_head_len   = w_head_word[LEN_LSB +: LEN_W];
    assign w_head_mode  = parity_t'(w_head_word[PAR_LSB +: 2]);
    assign w_head_stop2 = w_head_word[STOP_BIT];

    always_comb begin
        w_head_data_ext              = '0;
        w_head_data_ext[DATA_W-1:0]  = w_head_data;
    end

    assign w_head_parity = calc_parity(w_head_data_ext, w_head_len, w_head_mode);

    // ---------------------------------------------------------------------
    // Transmit FSM
    // ---------------------------------------------------------------------
    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_bit_cnt;     // data bits already placed on the line
    logic              r_par_en;
    logic              r_parity;
    logic              r_stop2;
    logic              r_stop_cnt;    // 0 during first stop bit, 1 during second
    logic              r_data_out;
    logic              r_tx_active;
    logic              r_tx_done;
    logic              w_last_stop;

    assign w_last_stop = (r_state == STOP) && (r_stop_cnt == r_stop2);

    // The head word is taken either from idle or straight out of the last
    // stop bit, which is what gives gap-free back-to-back frames.
    assign w_pop = !w_fifo_empty && ((r_state == IDLE) || w_last_stop);

    always_ff @(posedge BaudOut or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_len       <= '0;
            r_bit_cnt   <= '0;
            r_par_en    <= 1'b0;
            r_parity    <= 1'b0;
            r_stop2     <= 1'b0;
            r_stop_cnt  <= 1'b0;
            r_data_out  <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_data_out  <= 1'b1;
                    r_tx_active <= 1'b0;
                end

                START: begin
                    r_state    <= DATA;
                    r_data_out <= r_shift[0];
                    r_shift    <= r_shift >> 1;
                    r_bit_cnt  <= LEN_W'(1);
                end

                DATA: begin
                    if (r_bit_cnt == r_len) begin
                        if (r_par_en) begin
                            r_state    <= PARITY;
                            r_data_out <= r_parity;
                        end else begin
                            r_state    <= STOP;
                            r_data_out <= 1'b1;
                            r_stop_cnt <= 1'b0;
                        end
                    end else begin
                        r_data_out <= r_shift[0];
                        r_shift    <= r_shift >> 1;
                        r_bit_cnt  <= r_bit_cnt + LEN_W'(1);
                    end
                end

                PARITY: begin
                    r_state    <= STOP;
                    r_data_out <= 1'b1;
                    r_stop_cnt <= 1'b0;
                end

                STOP: begin
                    if (w_last_stop) begin
                        // Frame complete; a pending word overrides this below.
                        r_tx_done   <= 1'b1;
                        r_state     <= IDLE;
                        r_data_out  <= 1'b1;
                        r_tx_active <= 1'b0;
                    end else begin
                        r_stop_cnt <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_data_out  <= 1'b1;
                    r_tx_active <= 1'b0;
                end
            endcase

            // Loading the head word takes precedence over the idle/stop
            // defaults above; the frame's parity is latched here and held
            // until the next load.
            if (w_pop) begin
                r_state     <= START;
                r_data_out  <= 1'b0;
                r_tx_active <= 1'b1;
                r_shift     <= w_head_data;
                r_len       <= w_head_len;
                r_par_en    <= parity_enabled(w_head_mode);
                r_parity    <= w_head_parity;
                r_stop2     <= w_head_stop2;
            end
        end
    end

    assign data_out     = r_data_out;
    assign p_parity_out = r_parity;
    assign tx_active    = r_tx_active;
    assign tx_done      = r_tx_done;

endmodule

// File: tb/tb_piso_tx_param.sv
// ---------------------------------------------------------------------------
// tb_piso_tx_param
// Self-checking bench for piso_tx_param (DATA_W=8, FIFO_DEPTH=4). A
// frame-level model keeps a queue of accepted words and, for the frame in
// flight, the list of line bits still to be sent; every cycle the DUT outputs
// are compared with what that model predicts.
// ---------------------------------------------------------------------------
module tb_piso_tx_param;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int VW         = CW + 5;

    // {ready, data_out, p_parity_out, tx_active, tx_done, fifo_count}
    localparam logic [VW-1:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}};

    logic              BaudOut;
    logic              rst;
    logic              send;
    logic [DATA_W-1:0] data_in;
    logic [3:0]        data_length;
    logic [1:0]        parity_type;
    logic              stop_bits;
    logic              ready;
    logic              data_out;
    logic              p_parity_out;
    logic              tx_active;
    logic              tx_done;
    logic [CW-1:0]     fifo_count;
    logic [VW-1:0]     obs_vec;

    int n_checks;
    int n_fail;
    int cyc;

    piso_tx_param #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .BaudOut      (BaudOut),
        .rst          (rst),
        .send         (send),
        .data_in      (data_in),
        .data_length  (data_length),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .ready        (ready),
        .data_out     (data_out),
        .p_parity_out (p_parity_out),
        .tx_active    (tx_active),
        .tx_done      (tx_done),
        .fifo_count   (fifo_count)
    );

    assign obs_vec = {ready, data_out, p_parity_out, tx_active, tx_done, fifo_count};

    initial begin
        BaudOut = 1'b0;
        forever #5 BaudOut = ~BaudOut;
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    typedef struct {
        logic [DATA_W-1:0] data;
        int                len;
        logic [1:0]        ptype;
        logic              stop2;
    } word_t;

    word_t m_fifo[$];
    logic  m_line[$];   // m_line[0] is the bit on the line this cycle
    logic  m_par;
    logic  m_done;

    task automatic model_clear();
        m_fifo.delete();
        m_line.delete();
        m_par  = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic load_frame(input word_t w);
        int   ones;
        logic par;
        ones = 0;
        m_line.delete();
        m_line.push_back(1'b0);
        for (int i = 0; i < w.len; i++) begin
            m_line.push_back(w.data[i]);
            ones += int'(w.data[i]);
        end
        if (w.ptype == 2'b10)      par = (ones % 2) == 1;
        else if (w.ptype == 2'b01) par = (ones % 2) == 0;
        else                       par = 1'b0;
        if (w.ptype == 2'b01 || w.ptype == 2'b10) m_line.push_back(par);
        m_line.push_back(1'b1);
        if (w.stop2) m_line.push_back(1'b1);
        m_par = par;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic line_e;
        line_e = (m_line.size() > 0) ? m_line[0] : 1'b1;
        return {m_fifo.size() < FIFO_DEPTH, line_e, m_par, m_line.size() > 0,
                m_done, CW'(m_fifo.size())};
    endfunction

    function automatic logic model_busy();
        return (m_line.size() > 0) || (m_fifo.size() > 0) || m_done;
    endfunction

    task automatic set_in(input logic s, input logic [DATA_W-1:0] d,
                          input logic [3:0] l, input logic [1:0] p, input logic st);
        send        = s;
        data_in     = d;
        data_length = l;
        parity_type = p;
        stop_bits   = st;
    endtask

    // One bit period: advance the model on the rising edge, return at the
    // falling edge where outputs are sampled and new inputs are driven.
    task automatic tick();
        word_t w;
        logic  can_push;
        @(posedge BaudOut);
        cyc++;
        if (!rst) begin
            model_clear();
        end else begin
            can_push = send && (m_fifo.size() < FIFO_DEPTH);
            m_done   = 1'b0;
            if (m_line.size() > 0) begin
                m_line.delete(0);
                if (m_line.size() == 0) m_done = 1'b1;
            end
            if (m_line.size() == 0 && m_fifo.size() > 0) begin
                w = m_fifo.pop_front();
                load_frame(w);
            end
            if (can_push) begin
                w.data  = data_in;
                w.len   = (int'(data_length) < 5 || int'(data_length) > DATA_W)
                          ? DATA_W : int'(data_length);
                w.ptype = parity_type;
                w.stop2 = stop_bits;
                m_fifo.push_back(w);
                $display("push cyc=%0d data=%h len=%0d parity=%0d stop2=%0d buffered=%0d",
                         cyc, w.data, w.len, w.ptype, w.stop2, m_fifo.size());
            end
        end
        @(negedge BaudOut);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && model_busy(); i++) begin
            tick();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, obs_vec, exp_vec());
            end
        end
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
        model_clear();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (obs_vec !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_async got=%b want=%b", obs_vec, RESET_VEC);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec());
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_frame_vector(input string name, input logic [DATA_W-1:0] d,
                                     input logic [3:0] l, input logic [1:0] p,
                                     input logic st, input logic [15:0] seq,
                                     input int nbits, input logic par);
        drain({name, "_pre"});
        set_in(1'b1, d, l, p, st);
        tick();
        n_checks++;
        if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL %s_push got=%b want=%b", name, obs_vec, exp_vec());
        end
        set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            tick();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s_model bit=%0d got=%b want=%b", name, i, obs_vec, exp_vec());
            end
            n_checks++;
            if (data_out !== seq[i] || tx_done !== 1'b0 || p_parity_out !== par) begin
                n_fail++;
                $display("FAIL %s_line bit=%0d got line=%b done=%b par=%b want line=%b done=0 par=%b",
                         name, i, data_out, tx_done, p_parity_out, seq[i], par);
            end
        end
        tick();
        n_checks++;
        if (tx_done !== 1'b1 || tx_active !== 1'b0 || data_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done got done=%b active=%b line=%b want 1 0 1",
                     name, tx_done, tx_active, data_out);
        end
        tick();
        n_checks++;
        if (tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_width got=%b want=0", name, tx_done);
        end
    endtask

    task automatic test_back_to_back();
        int   active_cycles;
        int   rises;
        int   dones;
        logic prev_active;
        active_cycles = 0;
        rises         = 0;
        dones         = 0;
        prev_active   = 1'b0;
        drain("b2b_pre");
        for (int k = 0; k < 43; k++) begin
            if (k < 3) set_in(1'b1, DATA_W'($urandom), 4'd8, 2'b00, 1'b0);
            else       set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
            tick();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec());
            end
            if (tx_active === 1'b1) active_cycles++;
            if (tx_active === 1'b1 && prev_active === 1'b0) rises++;
            if (tx_done === 1'b1) dones++;
            prev_active = tx_active;
        end
        n_checks++;
        if (active_cycles != 30 || rises != 1 || dones != 3) begin
            n_fail++;
            $display("FAIL b2b_summary got active=%0d starts=%0d done=%0d want 30 1 3",
                     active_cycles, rises, dones);
        end
    endtask

    task automatic test_overflow();
        drain("ovf_pre");
        set_in(1'b1, 8'hC3, 4'd8, 2'b00, 1'b0);
        tick();
        set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
        tick();
        n_checks++;
        if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL ovf_busy got=%b want=%b", obs_vec, exp_vec());
        end
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, DATA_W'(8'h11 * (k + 1)), 4'd8, 2'b00, 1'b0);
            tick();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_model push=%0d got=%b want=%b", k, obs_vec, exp_vec());
            end
            n_checks++;
            if (ready !== (k < 3) || fifo_count !== CW'((k < 4) ? k + 1 : 4)) begin
                n_fail++;
                $display("FAIL ovf_ready push=%0d got ready=%b count=%0d want ready=%b count=%0d",
                         k, ready, fifo_count, (k < 3), (k < 4) ? k + 1 : 4);
            end
        end
        set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
        drain("ovf_drain");
    endtask

    task automatic test_short_len();
        int active_cycles;
        active_cycles = 0;
        drain("len_pre");
        set_in(1'b1, 8'h96, 4'd3, 2'b00, 1'b0);
        tick();
        set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
        for (int k = 0; k < 15; k++) begin
            tick();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL len_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec());
            end
            if (tx_active === 1'b1) active_cycles++;
        end
        n_checks++;
        if (active_cycles != 10) begin
            n_fail++;
            $display("FAIL len_clamp got active=%0d want 10", active_cycles);
        end
    endtask

    task automatic test_reset_mid_frame();
        drain("rstmid_pre");
        set_in(1'b1, 8'h5A, 4'd8, 2'b10, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 1 || k == 2) set_in(1'b1, 8'h77, 4'd6, 2'b01, 1'b1);
            else                  set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
            tick();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rstmid_model cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec());
            end
        end
        set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
        // Now inside the third data bit; reset between edges.
        #2 rst = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (obs_vec !== RESET_VEC) begin
            n_fail++;
            $display("FAIL rstmid_async got=%b want=%b", obs_vec, RESET_VEC);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rstmid_hold cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec());
            end
        end
        rst = 1'b1;
        set_in(1'b1, 8'h3C, 4'd8, 2'b01, 1'b1);
        tick();
        n_checks++;
        if (fifo_count !== CW'(1) || obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL rstmid_first_send got=%b want=%b", obs_vec, exp_vec());
        end
        set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
        drain("rstmid_drain");
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            set_in(($urandom_range(0, 2) == 0), DATA_W'($urandom),
                   4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
            tick();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs_vec, exp_vec());
            end
        end
        set_in(1'b0, '0, 4'd8, 2'b00, 1'b0);
        drain("random_drain");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        test_reset();
        test_frame_vector("a5_even", 8'hA5, 4'd8, 2'b10, 1'b0, 16'h054A, 11, 1'b0);
        test_frame_vector("41_odd",  8'h41, 4'd7, 2'b01, 1'b1, 16'h0782, 11, 1'b1);
        test_back_to_back();
        test_overflow();
        test_short_len();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
